// File: rtl/srl_fifo_ireg.sv
// srl_fifo_ireg: an SRL-based FIFO whose write side passes through a
// one-word input register, so the producer never drives the shift register
// directly. The consumer reads the SRL head straight out of the array.
// Total capacity is 2**l2depth words in the SRL plus one in the input register.
module srl_fifo_ireg #(
   parameter int width   = 128,
   parameter int l2depth = 5
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CLR,
   input  logic             ENQ,
   input  logic [width-1:0] D_IN,
   output logic             FULL_N,
   input  logic             DEQ,
   output logic             EMPTY_N,
   output logic [width-1:0] D_OUT
);

   localparam int depth = 2 ** l2depth;

   localparam logic [l2depth:0] cnt_one      = (l2depth + 1)'(1);
   localparam logic [l2depth:0] cnt_depth    = (l2depth + 1)'(depth);
   localparam logic [l2depth:0] cnt_depth_m1 = (l2depth + 1)'(depth - 1);

   // input register stage
   logic [width-1:0] ireg_reg;
   logic             ifull_reg;
   logic             ifull_next;

   // shift-register storage; dat_reg[0] is the most recently shifted-in word
   logic [width-1:0] dat_reg [depth];

   // occupancy of the SRL only (the input register is tracked by ifull_reg)
   logic [l2depth:0] cnt_reg;
   logic [l2depth:0] cnt_next;
   logic             sempty_reg;
   logic             sempty_next;
   logic             sfull_reg;
   logic             sfull_next;

   // per-cycle moves
   logic             xfer;
   logic             enq_ok;
   logic             deq_ok;
   logic [l2depth-1:0] head_idx;

   // Moves between stages; xfer depends only on flops so that the producer's
   // ENQ never reaches the SRL shift enable combinationally.
   always_comb begin
      xfer   = ifull_reg & ~sfull_reg;
      enq_ok = ENQ & FULL_N;
      deq_ok = DEQ & ~sempty_reg;
   end

   // Next-state for the input flag, occupancy and the registered SRL flags.
   always_comb begin
      ifull_next = enq_ok | (ifull_reg & ~xfer);

      cnt_next = cnt_reg;
      if (xfer & ~deq_ok) begin
         cnt_next = cnt_reg + cnt_one;
      end else if (deq_ok & ~xfer) begin
         cnt_next = cnt_reg - cnt_one;
      end

      sempty_next = ((cnt_reg == '0) & ~xfer)
                  | ((cnt_reg == cnt_one) & deq_ok & ~xfer);

      sfull_next  = ((cnt_reg == cnt_depth) & ~deq_ok)
                  | ((cnt_reg == cnt_depth_m1) & xfer & ~deq_ok);
   end

   // Control state; reset and CLR both empty the queue and ignore ENQ/DEQ.
   always_ff @(posedge CLK) begin
      if (!RST_N || CLR) begin
         ifull_reg  <= 1'b0;
         cnt_reg    <= '0;
         sempty_reg <= 1'b1;
         sfull_reg  <= 1'b0;
      end else begin
         ifull_reg  <= ifull_next;
         cnt_reg    <= cnt_next;
         sempty_reg <= sempty_next;
         sfull_reg  <= sfull_next;
      end
   end

   // Input data register; no reset so it maps onto plain enable flops.
   always_ff @(posedge CLK) begin
      if (enq_ok) begin
         ireg_reg <= D_IN;
      end
   end

   // Shift-register body; kept reset-free so it can be packed into SRLs.
   always_ff @(posedge CLK) begin
      if (xfer) begin
         dat_reg[0] <= ireg_reg;
         for (int i = 1; i < depth; i++) begin
            dat_reg[i] <= dat_reg[i-1];
         end
      end
   end

   // Head index is cnt-1 taken modulo depth; adding all-ones subtracts one
   // without widening, and cnt==depth correctly maps to depth-1.
   assign head_idx = cnt_reg[l2depth-1:0] + {l2depth{1'b1}};

   assign FULL_N  = ~(ifull_reg & sfull_reg);
   assign EMPTY_N = ~sempty_reg;
   assign D_OUT   = dat_reg[head_idx];

endmodule

// File: tb/tb_srl_fifo_ireg.sv
// Directed bench for srl_fifo_ireg with a small SRL (depth 4, capacity 5).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_srl_fifo_ireg;

   localparam int W  = 16;
   localparam int L2 = 2;

   logic         clk;
   logic         rst_n;
   logic         clr;
   logic         enq;
   logic         deq;
   logic [W-1:0] d_in;
   logic         full_n;
   logic         empty_n;
   logic [W-1:0] d_out;

   int tests_run;
   int tests_failed;

   srl_fifo_ireg #(.width(W), .l2depth(L2)) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .CLR     (clr),
      .ENQ     (enq),
      .D_IN    (d_in),
      .FULL_N  (full_n),
      .DEQ     (deq),
      .EMPTY_N (empty_n),
      .D_OUT   (d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single comparison point: counts and reports every check
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0h", tag, got);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // reset with ENQ/DEQ asserted to show they are ignored during reset
   task automatic do_reset();
      rst_n = 1'b0; clr = 1'b0; enq = 1'b1; deq = 1'b1; d_in = 16'hDEAD;
      clk1();
      clk1();
      rst_n = 1'b1; enq = 1'b0; deq = 1'b0;
      check("rst_full_n", 32'(full_n), 1);
      check("rst_empty_n", 32'(empty_n), 0);
      clk1();
      check("rst_idle_empty_n", 32'(empty_n), 0);
   endtask

   initial begin
      int tx;
      int rx;
      int gaps;
      tests_run = 0;
      tests_failed = 0;
      rst_n = 1'b0; clr = 1'b0; enq = 1'b0; deq = 1'b0; d_in = '0;

      // ---- 1: single word latency ----
      do_reset();
      enq = 1'b1; d_in = 16'h00A5;
      check("t1_c0_full_n", 32'(full_n), 1);
      clk1();
      enq = 1'b0;
      check("t1_c1_full_n", 32'(full_n), 1);
      check("t1_c1_empty_n", 32'(empty_n), 0);
      clk1();
      check("t1_c2_empty_n", 32'(empty_n), 1);
      check("t1_c2_d_out", 32'(d_out), 32'h00A5);
      check("t1_c2_full_n", 32'(full_n), 1);
      clk1();
      check("t1_c3_d_out", 32'(d_out), 32'h00A5);
      deq = 1'b1;
      clk1();
      deq = 1'b0;
      check("t1_c4_empty_n", 32'(empty_n), 0);
      check("t1_c4_full_n", 32'(full_n), 1);

      // ---- 2: fill past capacity, then drain ----
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         enq = 1'b1; d_in = 16'(i);
         check($sformatf("t2_full_n_w%0d", i), 32'(full_n), (i <= 5) ? 1 : 0);
         clk1();
      end
      enq = 1'b0;
      check("t2_full_n_after", 32'(full_n), 0);
      check("t2_head", 32'(d_out), 1);
      deq = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         check($sformatf("t2_empty_n_r%0d", j), 32'(empty_n), 1);
         check($sformatf("t2_d_out_r%0d", j), 32'(d_out), 32'(j));
         clk1();
         if (j == 1) check("t2_full_n_after_deq", 32'(full_n), 1);
      end
      deq = 1'b0;
      check("t2_empty_after_drain", 32'(empty_n), 0);
      clk1();
      check("t2_no_word6", 32'(empty_n), 0);

      // ---- 3: streaming 100 words with ENQ and DEQ held ----
      do_reset();
      tx = 0; rx = 0; gaps = 0;
      for (int cyc = 0; cyc < 400 && rx < 100; cyc++) begin
         logic accepted;
         enq  = (tx < 100);
         d_in = 16'(tx);
         deq  = 1'b1;
         accepted = enq & full_n;
         if (empty_n) begin
            check($sformatf("t3_word%0d", rx), 32'(d_out), 32'(rx));
            rx++;
         end else if (rx > 0 && rx < 100) begin
            gaps++;
         end
         clk1();
         if (accepted) tx++;
      end
      enq = 1'b0; deq = 1'b0;
      check("t3_sent", 32'(tx), 100);
      check("t3_received", 32'(rx), 100);
      check("t3_gaps", 32'(gaps), 0);
      check("t3_empty_end", 32'(empty_n), 0);

      // ---- 4: ENQ+DEQ while full: ENQ dropped, head advances ----
      do_reset();
      for (int i = 0; i < 5; i++) begin
         enq = 1'b1; d_in = 16'(16'h11 + i);
         clk1();
      end
      enq = 1'b0;
      check("t4_full_n", 32'(full_n), 0);
      check("t4_head", 32'(d_out), 32'h11);
      enq = 1'b1; deq = 1'b1; d_in = 16'h0099;
      clk1();
      enq = 1'b0; deq = 1'b0;
      check("t4_full_n_next", 32'(full_n), 1);
      check("t4_head_adv", 32'(d_out), 32'h12);
      enq = 1'b1; d_in = 16'h0016;
      check("t4_enq_ready", 32'(full_n), 1);
      clk1();
      enq = 1'b0;
      check("t4_full_again", 32'(full_n), 0);
      deq = 1'b1;
      for (int j = 0; j < 5; j++) begin
         check($sformatf("t4_drain%0d", j), 32'(d_out), 32'(32'h12 + j));
         clk1();
      end
      deq = 1'b0;
      check("t4_empty_end", 32'(empty_n), 0);

      // ---- 5: CLR with ENQ and DEQ asserted ----
      do_reset();
      for (int i = 0; i < 3; i++) begin
         enq = 1'b1; d_in = 16'(16'h31 + i);
         clk1();
      end
      enq = 1'b0;
      clk1();
      check("t5_before_clr_head", 32'(d_out), 32'h31);
      clr = 1'b1; enq = 1'b1; deq = 1'b1; d_in = 16'h00EE;
      clk1();
      clr = 1'b0; enq = 1'b0; deq = 1'b0;
      check("t5_clr_empty_n", 32'(empty_n), 0);
      check("t5_clr_full_n", 32'(full_n), 1);
      clk1();
      check("t5_clr_enq_ignored", 32'(empty_n), 0);
      enq = 1'b1; d_in = 16'h0077;
      clk1();
      enq = 1'b0;
      check("t5_77_c1_empty_n", 32'(empty_n), 0);
      clk1();
      check("t5_77_c2_empty_n", 32'(empty_n), 1);
      check("t5_77_d_out", 32'(d_out), 32'h77);

      // ---- 6: DEQ on empty, then one word ----
      do_reset();
      deq = 1'b1;
      for (int i = 0; i < 10; i++) begin
         clk1();
         check($sformatf("t6_empty_n_%0d", i), 32'(empty_n), 0);
         check($sformatf("t6_full_n_%0d", i), 32'(full_n), 1);
      end
      deq = 1'b0;
      enq = 1'b1; d_in = 16'h005C;
      clk1();
      enq = 1'b0;
      clk1();
      check("t6_empty_n", 32'(empty_n), 1);
      check("t6_d_out", 32'(d_out), 32'h5C);
      deq = 1'b1;
      clk1();
      deq = 1'b0;
      check("t6_empty_after", 32'(empty_n), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // hard bound on simulation time
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
